// File: rtl/mxint8_block_deserializer_pkg.sv
// mxint8_block_deserializer_pkg: shared MXINT8 block-stream constants and helpers
package mxint8_block_deserializer_pkg;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int BLOCK_SIZE = 32;
  localparam int SCALE_WIDTH = 8;
  localparam int MXINT8_LANES = 4;
  function automatic int cnt_width(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/mxint8_block_deserializer.sv
// mxint8_block_deserializer: assembles LANES-wide beats into a full MXINT8 block with shared scale
module mxint8_block_deserializer
  import mxint8_block_deserializer_pkg::*;
#(
  parameter int BLOCK_SIZE = mxint8_block_deserializer_pkg::BLOCK_SIZE,
  parameter int ELEMENT_WIDTH = MXINT8_ELEMENT_WIDTH,
  parameter int SCALE_WIDTH = mxint8_block_deserializer_pkg::SCALE_WIDTH,
  parameter int LANES = MXINT8_LANES
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*ELEMENT_WIDTH-1:0] i_data,
  input  logic [SCALE_WIDTH-1:0]     i_scale,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SCALE_WIDTH-1:0]     o_scale,
  output logic [ELEMENT_WIDTH-1:0]   o_mxint8_elements [BLOCK_SIZE],
  output logic                       o_err
);
  localparam int BEATS = BLOCK_SIZE / LANES;
  localparam int CW = cnt_width(BEATS);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, widx;
  logic accept, last_beat, frame_err;
  logic [BLOCK_SIZE-1:0] we;
  assign o_valid = state == FULL;
  assign o_ready = state == FULL ? i_ready : 1'b1;
  assign accept = i_valid && o_ready;
  // a beat taken in IDLE or during the FULL transfer cycle always starts a new block
  assign widx = state == FILL ? cnt : '0;
  assign last_beat = widx == CW'(BEATS - 1);
  assign frame_err = accept && (i_last != last_beat);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (accept) begin
      state_n = frame_err ? IDLE : (last_beat ? FULL : FILL);
      cnt_n = (frame_err || last_beat) ? '0 : widx + 1'b1;
    end else if (o_valid && i_ready) begin
      state_n = IDLE;
    end
  end
  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_we
    assign we[g] = accept && widx == CW'(g / LANES);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      o_err <= 1'b0;
      o_scale <= '0;
      for (int n = 0; n < BLOCK_SIZE; n++) o_mxint8_elements[n] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_err <= frame_err;
      if (accept && widx == '0) o_scale <= i_scale;
      for (int n = 0; n < BLOCK_SIZE; n++)
        if (we[n]) o_mxint8_elements[n] <= i_data[(n % LANES)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
  end
endmodule
